// File: rtl/multi_debouncer.sv
// N-channel push-button conditioner: sync, debounce, press/release strobes, long-press detection.
// Optional auto-repeat strobes are built when DEBOUNCE_REPEAT_EN is defined; otherwise o_rpt is tied to 0.
module multi_debouncer #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 262144,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 20000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] i_btn,
  output logic [CHANNELS-1:0] o_state,
  output logic [CHANNELS-1:0] o_ondn,
  output logic [CHANNELS-1:0] o_onup,
  output logic [CHANNELS-1:0] o_long,
  output logic [CHANNELS-1:0] o_rpt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } ch_state_e;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("multi_debouncer: all parameters must be >= 1");
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic          sync0;
    logic          sync1;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    ch_state_e     state;
    ch_state_e     state_next;
    logic          level;
    logic          toggle;
    logic          long_hit;
    logic          rpt_hit;
    logic          ondn_d, onup_d, long_d, rpt_d;
    logic          ondn_q, onup_q, long_q, rpt_q;

    assign level    = (state != IDLE);
    assign toggle   = (sync1 != level) && (deb_cnt == DEB_LAST);
    assign long_hit = (hold_cnt == HOLD_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync0 <= 1'b0;
        sync1 <= 1'b0;
      end else begin
        sync0 <= i_btn[k];
        sync1 <= sync0;
      end
    end

    // Any cycle where the synchronised input agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt <= '0;
      end else if (sync1 == level || toggle) begin
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end

    // Holds at zero through the press-strobe cycle, then counts up and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_cnt <= '0;
      end else if (state == IDLE) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rpt_cnt;

    assign rpt_hit = (rpt_cnt == RPT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rpt_cnt <= '0;
      end else if (state != HELD || rpt_hit) begin
        rpt_cnt <= '0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
      end else begin
        state <= state_next;
      end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
      state_next = state;
      case (state)
        IDLE:    if (toggle) state_next = PRESSED;
        PRESSED: begin
          if (toggle)        state_next = IDLE;
          else if (long_hit) state_next = HELD;
        end
        HELD:    if (toggle) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end

    // A release toggle on the same edge suppresses the long-press and repeat strobes.
    always_comb begin
      ondn_d = 1'b0;
      onup_d = 1'b0;
      long_d = 1'b0;
      rpt_d  = 1'b0;
      case (state)
        IDLE:    ondn_d = toggle;
        PRESSED: begin
          onup_d = toggle;
          long_d = long_hit && !toggle;
        end
        HELD:    begin
          onup_d = toggle;
          rpt_d  = rpt_hit && !toggle;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ondn_q <= 1'b0;
        onup_q <= 1'b0;
        long_q <= 1'b0;
        rpt_q  <= 1'b0;
      end else begin
        ondn_q <= ondn_d;
        onup_q <= onup_d;
        long_q <= long_d;
        rpt_q  <= rpt_d;
      end
    end

    assign o_state[k] = level;
    assign o_ondn[k]  = ondn_q;
    assign o_onup[k]  = onup_q;
    assign o_long[k]  = long_q;
    assign o_rpt[k]   = rpt_q;
  end

endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised N-channel push-button conditioner for the board's button and switch inputs. Each channel synchronises its raw input, filters bounce with a programmable stable-time counter, and produces a clean level plus one-cycle press and release strobes. It also detects long presses and, optionally, generates auto-repeat strobes for menu-style navigation in the user-interface layer.

## Interface
- CHANNELS, 4, number of independent input channels (≥1)
- DEBOUNCE_CYCLES, 262144, consecutive mismatching cycles required to accept a new level (≥1; 2.6 ms at 100 MHz)
- HOLD_CYCLES, 100000000, cycles a press must be held before the long-press strobe (≥1)
- REPEAT_CYCLES, 20000000, auto-repeat period after the long press (≥1)
- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  reset, asynchronous, active-low
- i_btn  input  CHANNELS  raw asynchronous inputs, bit k = channel k, active-high
- o_state  output  CHANNELS  debounced level per channel
- o_ondn  output  CHANNELS  one-cycle strobe: o_state just went 0→1 (press)
- o_onup  output  CHANNELS  one-cycle strobe: o_state just went 1→0 (release)
- o_long  output  CHANNELS  one-cycle strobe: press held HOLD_CYCLES
- o_rpt  output  CHANNELS  one-cycle auto-repeat strobe (see Configuration)

## Operation
- Channels are fully independent; no shared counters. Implemented as a generate loop over one per-channel datapath.
- Sync: two-flop synchroniser per channel (sync0 ← i_btn[k], sync1 ← sync0), both reset to 0.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES+1).
  - If sync1 == o_state: counter ← 0 (idle; any bounce back restarts the count).
  - Otherwise, if counter == DEBOUNCE_CYCLES-1: o_state toggles and counter ← 0.
  - Otherwise: counter ← counter + 1.
- Strobes o_ondn/o_onup are registered. Each is high for exactly the one cycle in which o_state shows its new value.
- Hold counter: width $clog2(HOLD_CYCLES+1). Cleared while o_state=0 and in the o_ondn cycle; incremented each cycle while o_state=1 until it saturates at HOLD_CYCLES.
  - o_long pulses in the cycle the counter reaches HOLD_CYCLES: HOLD_CYCLES cycles after the o_ondn cycle. It pulses once per press.
- Per-channel state: IDLE (o_state=0), PRESSED (o_state=1, before o_long), HELD (after o_long). The release transition from PRESSED or HELD returns to IDLE.
- Simultaneous events:
  - If a release toggle lands on the edge where o_long would fire, the release wins: o_onup only, no o_long.
  - The same rule applies to o_rpt.
- Reset, including mid-count: every register and output returns to 0 immediately.
  - If an input is high at reset release, it is treated as a press: o_ondn fires after the normal latency.

## Timing
- Reset values: o_state, o_ondn, o_onup, o_long, o_rpt all 0.
- Press/release latency: for an input that changes and then stays stable, o_state and its strobe update on the (DEBOUNCE_CYCLES+2)th rising edge. Counting starts at the first edge that samples the new level: 2 synchroniser edges plus DEBOUNCE_CYCLES counting edges.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- Minimum spacing between o_ondn and the next o_onup on a channel is DEBOUNCE_CYCLES cycles.
- All outputs are registered; there is no combinational path from i_btn to any output.

## Configuration
- Macro: DEBOUNCE_REPEAT_EN.
- Defined:
  - A repeat counter of width $clog2(REPEAT_CYCLES+1) runs in HELD state.
  - o_rpt pulses REPEAT_CYCLES cycles after o_long, then every REPEAT_CYCLES cycles while held.
  - The counter clears on release.
- Undefined: the repeat counter is not built and o_rpt is tied to 0. All other behaviour is identical.

## Test plan
All scenarios use CHANNELS=4, DEBOUNCE_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=5.
- Reset/idle: hold rst_n=0 with i_btn=4'b0000, release, run 50 cycles → all outputs stay 0.
- Clean press and release on ch0: i_btn[0] 0→1 and held → o_state[0]=1 and a single o_ondn[0] on the 10th edge. Then 1→0 → o_onup[0] on the 10th edge after the change.
- Bounce rejection on ch1: toggle i_btn[1] every 3 cycles for 40 cycles, then hold high → no strobes during the toggling; o_ondn[1] exactly 10 edges after the final rising edge.
- Long press and repeat on ch2: hold i_btn[2] high → o_long[2] 20 cycles after o_ondn[2].
  - With DEBOUNCE_REPEAT_EN: o_rpt[2] at +5, +10, +15 after o_long.
  - Without it: o_rpt stays 0.
  - On release: o_onup only.
- Concurrency and async reset: press ch0 and ch3 on the same cycle → simultaneous o_ondn=4'b1001. Assert rst_n=0 mid-count on ch1 → all outputs 0 without waiting for a clock edge.
- Boundary on ch0: release timed to land on the o_long edge → o_onup[0]=1, o_long[0]=0.
